// File: rtl/fifo_pkg.sv
// Shared constants and types for the FWFT adapter around the async FIFO read side.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 2;

    // Buffer occupancy, 0..2 words.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_FULL = 2'd2;

endpackage

// File: rtl/fwft_buf2.sv
// Two-entry output buffer: a write port, a head pointer and a pop.
// Occupancy is tracked by the owner; this block only stores and orders words.
module fwft_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (i_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_fwft_adapter.sv
// Turns a read-strobe FIFO with one cycle of read latency into a FWFT valid/ready stream.
// Define FIFO_FWFT_STALL_CNT_EN to add the o_stall_cnt saturating stall counter.
module fifo_fwft_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef FIFO_FWFT_STALL_CNT_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("fifo_fwft_adapter: only BUF_DEPTH == 2 is supported");
    end

    occ_t       r_occ;
    logic       r_inflight;
    logic       w_pop;
    logic [2:0] w_credit;

    assign o_valid = (r_occ != 2'd0);
    assign w_pop   = o_valid && i_ready;

    // Words held or arriving after this edge; a new read must keep it within the buffer.
    assign w_credit  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign o_fifo_rd = !i_rst && !i_fifo_empty && (w_credit < 3'd2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_credit[1:0];
            r_inflight <= o_fifo_rd;
        end
    end

    fwft_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (r_inflight),
        .i_wdata (i_fifo_data),
        .i_pop   (w_pop),
        .o_data  (o_data)
    );

    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
        !(r_inflight && (r_occ == OCC_FULL) && !w_pop));

`ifdef FIFO_FWFT_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (o_valid && !i_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Directed bench for fifo_fwft_adapter with a behavioural 1-cycle-latency FIFO read side.
// Stall-counter scenario is built only when FIFO_FWFT_STALL_CNT_EN is defined.
module tb_fifo_fwft_adapter;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_rdata;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
`ifdef FIFO_FWFT_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // FIFO model: words pushed by the stimulus, read with one cycle of latency.
    logic [DW-1:0] mem [256];
    int            wr_idx = 0;
    int            rd_idx = 0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx     <= wr_idx;
            fifo_rdata <= '0;
        end else if (fifo_rd) begin
            fifo_rdata <= mem[rd_idx % 256];
            rd_idx     <= rd_idx + 1;
        end
    end

    fifo_fwft_adapter #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (fifo_rd),
        .i_fifo_data  (fifo_rdata),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data)
`ifdef FIFO_FWFT_STALL_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_idx % 256] = w;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_valid=%b expected 1 within %0d cycles", name, valid, budget);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fifo_rd, valid, data} !== {1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_hold: rd=%b valid=%b data=%h expected 0 0 00",
                         fifo_rd, valid, data);
            end
        end
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        #1;
        checks++;
        if ({fifo_rd, valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_nonempty: rd=%b valid=%b expected 0 0", fifo_rd, valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_rd, valid} !== 2'b10) begin
            errors++;
            $display("FAIL first_read: rd=%b valid=%b expected 1 0", fifo_rd, valid);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_early: o_valid=%b expected 0", valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            else tick();
            checks++;
            if ({valid, data} !== {1'b1, 8'hA0 + 8'(i)}) begin
                errors++;
                $display("FAIL reset_drain[%0d]: valid=%b data=%h expected 1 %h",
                         i, valid, data, 8'hA0 + 8'(i));
            end
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_end: o_valid=%b expected 0", valid);
        end
    endtask

    task automatic test_stream();
        ready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        #1;
        wait_valid("stream_start", 5);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({valid, data} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b data=%h expected 1 %h", i, valid, data, 8'(i));
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: o_valid=%b expected 0", valid);
        end
    endtask

    task automatic test_backpressure();
        int reads = 0;
        ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        #1;
        for (int i = 0; i < 9; i++) begin
            if (fifo_rd) reads++;
            if (valid) begin
                checks++;
                if (data !== 8'h10) begin
                    errors++;
                    $display("FAIL hold_stable: o_data=%h expected 10", data);
                end
            end
            tick();
        end
        checks++;
        if (reads != 2) begin
            errors++;
            $display("FAIL bp_reads: reads=%0d expected 2", reads);
        end
        checks++;
        if ({valid, data} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h expected 1 10", valid, data);
        end
        ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({valid, data} !== {1'b1, 8'h10 + 8'(i)}) begin
                errors++;
                $display("FAIL bp_stream[%0d]: valid=%b data=%h expected 1 %h",
                         i, valid, data, 8'h10 + 8'(i));
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: o_valid=%b expected 0", valid);
        end
    endtask

    task automatic test_toggle();
        logic [DW-1:0] got [$];
        bit            rd_empty = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
        for (int c = 0; c < 20; c++) begin
            ready = c[0];
            #1;
            if (fifo_rd && fifo_empty) rd_empty = 1'b1;
            if (valid && ready) got.push_back(data);
            tick();
        end
        checks++;
        if (rd_empty) begin
            errors++;
            $display("FAIL toggle_rd_empty: read while empty=1 expected 0");
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL toggle_count: words=%0d expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL toggle_word[%0d]: data=%h expected %h", i, got[i], 8'h20 + 8'(i));
            end
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_end: o_valid=%b expected 0", valid);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        ready = 1'b1;
        #1;
        checks++;
        if ({valid, data, fifo_rd} !== {1'b1, 8'h30, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre: valid=%b data=%h rd=%b expected 1 30 1", valid, data, fifo_rd);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, data, fifo_rd} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h rd=%b expected 0 00 0", valid, data, fifo_rd);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, fifo_rd} !== 2'b00) begin
                errors++;
                $display("FAIL mid_stale[%0d]: valid=%b rd=%b expected 0 0", i, valid, fifo_rd);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
        #1;
        wait_valid("mid_restart", 5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, data} !== {1'b1, 8'h40 + 8'(i)}) begin
                errors++;
                $display("FAIL mid_stream[%0d]: valid=%b data=%h expected 1 %h",
                         i, valid, data, 8'h40 + 8'(i));
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_end: o_valid=%b expected 0", valid);
        end
    endtask

`ifdef FIFO_FWFT_STALL_CNT_EN
    task automatic test_stall_cnt();
        ready = 1'b0;
        push(8'h50);
        #1;
        wait_valid("stall_start", 5);
        repeat (70000) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_sat: o_stall_cnt=%h expected ffff", stall_cnt);
        end
        repeat (3) tick();
        checks++;
        if ({stall_cnt, valid, data} !== {16'hFFFF, 1'b1, 8'h50}) begin
            errors++;
            $display("FAIL stall_hold: cnt=%h valid=%b data=%h expected ffff 1 50",
                     stall_cnt, valid, data);
        end
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: o_valid=%b expected 0", valid);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_reset_mid();
`ifdef FIFO_FWFT_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_adapter.md
FIFO_FWFT_ADAPTER -- requirements
Module: fifo_fwft_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, width of a FIFO word and of o_data.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, output buffer entries; only value 2 is supported.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: i_clk and i_rst.
REQ-004 i_clk  input  1  clock; same clock as the async FIFO read side (i_rclk).
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_fifo_empty  input  1  FIFO read-side empty flag (o_rempty).
REQ-007 o_fifo_rd  output  1  read strobe to the FIFO (i_rd).
REQ-008 i_fifo_data  input  DATA_WIDTH  FIFO read data (o_rdata), valid the cycle after o_fifo_rd.
REQ-009 o_valid  output  1  downstream word valid.
REQ-010 i_ready  input  1  downstream accepts the word.
REQ-011 o_data  output  DATA_WIDTH  downstream word, head of the buffer.

Function
REQ-012 SHALL convert the FIFO's read-strobe/1-cycle-latency interface into a first-word-fall-through valid/ready stream.
REQ-013 SHALL track occ (0..2 words held) and inflight (1 = a read was issued last cycle).
REQ-014 pop = o_valid && i_ready; o_fifo_rd = !i_fifo_empty && (occ + inflight - pop) < 2; computed combinationally from registered state, i_ready and i_fifo_empty.
REQ-015 SHALL never assert o_fifo_rd while i_fifo_empty is high.
REQ-016 inflight SHALL register o_fifo_rd; when inflight is 1, i_fifo_data SHALL be written into the buffer at the next i_clk edge.
REQ-017 o_valid SHALL equal (occ != 0), registered; o_data SHALL be the oldest buffered word.
REQ-018 Latency: an o_fifo_rd at edge N yields o_valid at the output no later than edge N+2.
REQ-019 Simultaneous capture and pop SHALL leave occ unchanged and advance the head; words SHALL leave in FIFO order, none duplicated or dropped.
REQ-020 With i_ready held high and the FIFO never empty, o_valid SHALL stay high and one word SHALL transfer per cycle.
REQ-021 o_data and o_valid SHALL hold stable while o_valid && !i_ready.
REQ-022 occ SHALL never exceed 2; a capture with occ == 2 and no pop is an error that the credit rule in REQ-014 makes unreachable.

Reset
REQ-023 While i_rst is high: occ = 0, inflight = 0, o_valid = 0, o_data = 0, o_fifo_rd = 0.
REQ-024 A reset mid-operation SHALL discard buffered and in-flight words; the FIFO read side is reset by the same event.
REQ-025 The first o_fifo_rd SHALL occur no earlier than the first edge after i_rst deasserts.

Configuration
REQ-026 Macro FIFO_FWFT_STALL_CNT_EN SHALL add output o_stall_cnt [15:0]: a saturating count of cycles with o_valid && !i_ready, reset to 0 by i_rst.
REQ-027 Without FIFO_FWFT_STALL_CNT_EN, the port and counter SHALL be absent and function SHALL be otherwise identical.

Structure
REQ-028 Package fifo_pkg SHALL hold the default DATA_WIDTH constant and the occ count typedef (2 bits).
REQ-029 The 2-entry storage (write port, head pointer, pop) SHALL be a sub-module fwft_buf2; credit and strobe logic stay in fifo_fwft_adapter.

Verification
REQ-030 Reset with FIFO non-empty -> o_fifo_rd = 0 and o_valid = 0 throughout reset; first read on the first edge after release; o_valid high 2 edges later.
REQ-031 Push 16 words 0,1,2,3,... into the FIFO with i_ready = 1 -> all 16 words out in order, one per cycle after the first, o_valid never dropping.
REQ-032 i_ready = 0 with the FIFO full -> exactly 2 reads issued, occ = 2, o_data frozen at word 0; i_ready = 1 then streams words 0..N in order.
REQ-033 i_ready toggles every cycle while the FIFO empties at its last word -> no read issued while empty, last word delivered once, o_valid falls after it.
REQ-034 i_rst asserted with occ = 2 and a read in flight -> outputs zero immediately; after release no stale word appears; new data streams correctly.
REQ-035 With FIFO_FWFT_STALL_CNT_EN, hold o_valid high and i_ready low for 70000 cycles -> o_stall_cnt = 16'hFFFF and holds there.
